key_dispatcher: RTL and testbench
=================================

# key_dispatcher

Turns the keyboard keycode event stream (make/break bytes from the USB/NIOS PIO) into frame-stable movement commands for both players. It produces the per-player left/right/jump inputs that the FireBoy and IceGirl controllers consume, and presents them on frame boundaries only. It tracks the held state of six game keys and resolves left/right conflicts. It also converts jump presses into single-frame requests.

## Interface
- `ACTIVE_KEYS`, 6: number of tracked game keys (fixed mapping, see Operation).
- `Clk` input 1: system clock; all logic is on the rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state.
- `frame_clk` input 1: vertical-sync-rate frame clock, synchronous to `Clk`. Only its rising edge is used.
- `key_valid` input 1: one-cycle strobe; `key_code` and `key_make` are valid.
- `key_code` input 8: USB HID usage code.
- `key_make` input 1: 1 = press, 0 = release.
- `fireboy_dir` output 2: 00 none, 01 left, 10 right; 11 never driven.
- `fireboy_jump` output 1: one-`Clk` pulse per accepted jump press.
- `icegirl_dir` output 2: same encoding as `fireboy_dir`.
- `icegirl_jump` output 1: same behaviour as `fireboy_jump`.
- `frame_tick` output 1: one-`Clk` pulse marking the cycle in which the command outputs were updated.

## Operation
- **Key map:**
  - Fireboy: 0x04 (A) = left, 0x07 (D) = right, 0x1A (W) = jump.
  - Icegirl: 0x50 = left, 0x4F = right, 0x52 = jump.
  - Any other code is ignored with no state change.
- **Held state:** one held bit per tracked key.
  - Make sets the bit; break clears it.
  - A make on an already-held key (typematic repeat) changes nothing.
  - A break on a key that is not held changes nothing.
- **Direction resolve, per player:** a `last_dir` register records the most recently *pressed* direction.
  - Only left held → left. Only right held → right. Neither held → none.
  - Both held → the value of `last_dir` (last-press-wins).
  - Releasing one of two held directions falls back to the one still held.
- **Jump, per player:** a `jump_pend` flag.
  - It is set on a make of the jump key that moves the held bit 0→1.
  - It is cleared when delivered.
  - Holding the key never re-arms it; the player must release and press again.
  - Multiple press/release pairs within one frame collapse into a single pulse.
- **Frame tick:** `frame_clk` is registered into `fc_d`; the internal `tick` = `frame_clk & ~fc_d`, registered.
  - On `tick`, each `*_dir` output register loads its resolved direction.
  - On `tick`, each `*_jump` output register loads that player's `jump_pend`, and the delivered `jump_pend` clears.
  - On `tick`, `frame_tick` goes high for that cycle.
  - Between ticks, `*_dir` outputs hold their values and `*_jump`/`frame_tick` are 0.
- **Simultaneous events:** when `key_valid` and `tick` fall in the same cycle, the tick samples the state from *before* the event. The event is applied in that same cycle and is seen at the next tick.
- **Reset:**
  - Held bits, `last_dir`, `jump_pend`, `fc_d` and `tick` are cleared (`last_dir` to none).
  - All outputs go to 0 immediately (asynchronous).
  - A `frame_clk` that is already high on reset release does not generate a tick until it goes low and rises again.

## Timing
- Edge detect: `frame_clk` is sampled high at Clk edge k while `fc_d` is 0 → `tick` is high after edge k+1 → outputs and `frame_tick` update at edge k+2. Outputs are registered with no combinational path from inputs.
- Key event to held bit: registered at the edge where `key_valid` is sampled, one-cycle latency.
- The worst-case key-to-output delay is one frame plus 2 `Clk` cycles.
- `*_jump` and `frame_tick` pulses are exactly one `Clk` cycle wide and coincide with the cycle in which `*_dir` changes.
- There is no backpressure: a `key_valid` strobe is accepted every cycle, including back-to-back.

## Structure
- **Shared package `game_pkg`:**
  - Keycode constants `KEY_A`, `KEY_D`, `KEY_W`, `KEY_LEFT`, `KEY_RIGHT`, `KEY_UP`.
  - `typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t`.
  - Both player controllers also import this package.
- **Sub-module `player_key_channel`:** instantiated twice, parameterised by the three keycodes.
  - Contains the held bits, `last_dir`, `jump_pend` and the output registers.
  - Consumes the shared `tick` and the key event.
- **Top level:** contains only the frame-edge detector and the two instances.

## Test plan
- **Reset and idle:** assert `Reset`, then pulse `frame_clk` twice → both `*_dir` = 00, no jump pulses, `frame_tick` one cycle per rising edge.
- **Direction holds across frames:** make 0x07, then tick → `fireboy_dir` = 10, `icegirl_dir` = 00. No further input → stays 10 over the next 3 ticks. Break 0x07, then tick → 00.
- **Left/right conflict:** make 0x50, then make 0x4F, then tick → `icegirl_dir` = 10. Break 0x4F, then tick → 01.
- **Jump is edge-only:** make 0x1A, repeat make 0x1A ×5, then 3 ticks → `fireboy_jump` pulses only at the first tick. Break, make, then tick → one more pulse.
- **Same-cycle collision:** make 0x04 in the same cycle as `tick` → `fireboy_dir` stays 00 at that tick and becomes 01 at the next tick.
- **Unknown code and mid-operation reset:**
  - Make 0x29 → no change.
  - With `jump_pend` set, assert `Reset` mid-frame → outputs 0 at once and no jump pulse at the next tick.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game input path: tracked keycodes, direction
// encoding and the left/right conflict resolver used by both players.
package game_pkg;

    localparam int ACTIVE_KEYS  = 6;
    localparam int CHANNEL_KEYS = ACTIVE_KEYS / 2;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_UP    = 8'h52;

    localparam logic [1:0] IDX_LEFT  = 2'd0;
    localparam logic [1:0] IDX_RIGHT = 2'd1;
    localparam logic [1:0] IDX_JUMP  = 2'd2;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_t;

    // With both directions held the most recent press wins.
    function automatic dir_t resolve_dir(input logic left_held,
                                         input logic right_held,
                                         input dir_t last_dir);
        dir_t res;
        case ({left_held, right_held})
            2'b10:   res = DIR_LEFT;
            2'b01:   res = DIR_RIGHT;
            2'b11:   res = last_dir;
            default: res = DIR_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/player_key_channel.sv
// One player's key tracking: held bits, last pressed direction, pending jump,
// and the frame-stable direction/jump output registers.
module player_key_channel
    import game_pkg::*;
#(
    parameter logic [7:0] LEFT_CODE  = KEY_A,
    parameter logic [7:0] RIGHT_CODE = KEY_D,
    parameter logic [7:0] JUMP_CODE  = KEY_W
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       key_valid_i,
    input  logic [7:0] key_code_i,
    input  logic       key_make_i,
    output logic [1:0] dir_o,
    output logic       jump_o
);

    logic [CHANNEL_KEYS-1:0] held_q;
    logic [CHANNEL_KEYS-1:0] held_d;
    dir_t                    last_dir_q;
    dir_t                    last_dir_d;
    logic                    jump_pend_q;
    logic                    jump_pend_d;
    dir_t                    dir_q;
    dir_t                    dir_d;
    logic                    jump_q;
    logic                    jump_d;
    logic                    hit_s;
    logic [1:0]              idx_s;
    logic                    rise_s;

    // Map the incoming keycode onto this channel's key slots.
    always_comb begin
        hit_s = 1'b1;
        idx_s = IDX_LEFT;
        if (key_code_i == LEFT_CODE) begin
            idx_s = IDX_LEFT;
        end else if (key_code_i == RIGHT_CODE) begin
            idx_s = IDX_RIGHT;
        end else if (key_code_i == JUMP_CODE) begin
            idx_s = IDX_JUMP;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Held state, last press and jump arming; a tick in the same cycle
    // delivers the old pending flag while a new press re-arms it.
    always_comb begin
        held_d      = held_q;
        last_dir_d  = last_dir_q;
        jump_pend_d = tick_i ? 1'b0 : jump_pend_q;
        rise_s      = 1'b0;
        if (key_valid_i && hit_s) begin
            rise_s         = key_make_i & ~held_q[idx_s];
            held_d[idx_s]  = key_make_i;
            if (rise_s) begin
                case (idx_s)
                    IDX_LEFT:  last_dir_d  = DIR_LEFT;
                    IDX_RIGHT: last_dir_d  = DIR_RIGHT;
                    IDX_JUMP:  jump_pend_d = 1'b1;
                    default:   last_dir_d  = last_dir_q;
                endcase
            end else begin
                last_dir_d = last_dir_q;
            end
        end else begin
            held_d = held_q;
        end
    end

    // Output registers only move on a frame tick.
    always_comb begin
        if (tick_i) begin
            dir_d  = resolve_dir(held_q[IDX_LEFT], held_q[IDX_RIGHT], last_dir_q);
            jump_d = jump_pend_q;
        end else begin
            dir_d  = dir_q;
            jump_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_q      <= '0;
            last_dir_q  <= DIR_NONE;
            jump_pend_q <= 1'b0;
            dir_q       <= DIR_NONE;
            jump_q      <= 1'b0;
        end else begin
            held_q      <= held_d;
            last_dir_q  <= last_dir_d;
            jump_pend_q <= jump_pend_d;
            dir_q       <= dir_d;
            jump_q      <= jump_d;
        end
    end

    assign dir_o  = dir_q;
    assign jump_o = jump_q;

endmodule

// File: rtl/key_dispatcher.sv
// Keyboard event dispatcher: detects frame_clk rising edges and feeds one
// key channel per player, publishing commands only on frame ticks.
module key_dispatcher
    import game_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_make,
    output logic [1:0] fireboy_dir,
    output logic       fireboy_jump,
    output logic [1:0] icegirl_dir,
    output logic       icegirl_jump,
    output logic       frame_tick
);

    logic fc_sync_q;
    logic fc_dly_q;
    logic armed_q;
    logic armed_d;
    logic tick_q;
    logic tick_d;
    logic frame_tick_q;

    // A frame_clk seen low since reset arms the detector, so a level that
    // is already high at reset release cannot fake a rising edge.
    always_comb begin
        armed_d = armed_q | ~frame_clk;
        tick_d  = fc_sync_q & ~fc_dly_q & armed_q;
    end

    // Frame edge detector and frame_tick register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_sync_q    <= 1'b0;
            fc_dly_q     <= 1'b0;
            armed_q      <= 1'b0;
            tick_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            fc_sync_q    <= frame_clk;
            fc_dly_q     <= fc_sync_q;
            armed_q      <= armed_d;
            tick_q       <= tick_d;
            frame_tick_q <= tick_q;
        end
    end

    player_key_channel #(
        .LEFT_CODE  (KEY_A),
        .RIGHT_CODE (KEY_D),
        .JUMP_CODE  (KEY_W)
    ) u_fireboy (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .tick_i      (tick_q),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .key_make_i  (key_make),
        .dir_o       (fireboy_dir),
        .jump_o      (fireboy_jump)
    );

    player_key_channel #(
        .LEFT_CODE  (KEY_LEFT),
        .RIGHT_CODE (KEY_RIGHT),
        .JUMP_CODE  (KEY_UP)
    ) u_icegirl (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .tick_i      (tick_q),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .key_make_i  (key_make),
        .dir_o       (icegirl_dir),
        .jump_o      (icegirl_jump)
    );

    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_key_dispatcher.sv
// Self-checking bench for key_dispatcher: event-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_key_dispatcher;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_make;
    logic [1:0] fireboy_dir;
    logic       fireboy_jump;
    logic [1:0] icegirl_dir;
    logic       icegirl_jump;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    key_dispatcher dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_make     (key_make),
        .fireboy_dir  (fireboy_dir),
        .fireboy_jump (fireboy_jump),
        .icegirl_dir  (icegirl_dir),
        .icegirl_jump (icegirl_jump),
        .frame_tick   (frame_tick)
    );

    // Reference model: key sets, press timestamps, pending jumps.
    bit         held  [2][3];
    int         ptime [2][2];
    bit         pend  [2];
    logic [1:0] exp_dir  [2] = '{2'b00, 2'b00};
    bit         exp_jump [2] = '{1'b0, 1'b0};
    bit         exp_tick = 1'b0;
    bit         samp[$];
    int         cyc = 0;
    int         m_p, m_r, m_n;
    bit         m_deliver;

    int fb_pulses = 0;
    int ig_pulses = 0;
    int tick_pulses = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [7:0] code, output int p, output int r);
        p = -1;
        r = 0;
        case (code)
            8'h04: begin p = 0; r = 0; end
            8'h07: begin p = 0; r = 1; end
            8'h1A: begin p = 0; r = 2; end
            8'h50: begin p = 1; r = 0; end
            8'h4F: begin p = 1; r = 1; end
            8'h52: begin p = 1; r = 2; end
            default: p = -1;
        endcase
    endfunction

    function automatic logic [1:0] model_dir(input int p);
        if (held[p][0] && held[p][1]) return (ptime[p][0] > ptime[p][1]) ? 2'b01 : 2'b10;
        if (held[p][0]) return 2'b01;
        if (held[p][1]) return 2'b10;
        return 2'b00;
    endfunction

    // A frame_clk rising edge (high sample preceded by a low sample, both
    // taken after reset) updates the outputs two edges after the high sample.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int r = 0; r < 3; r++) held[p][r] = 1'b0;
                ptime[p][0] = 0;
                ptime[p][1] = 0;
                pend[p]     = 1'b0;
                exp_dir[p]  = 2'b00;
                exp_jump[p] = 1'b0;
            end
            exp_tick = 1'b0;
            samp.delete();
            cyc = 0;
        end else begin
            cyc++;
            m_n = samp.size();
            m_deliver = (m_n >= 3) && samp[m_n-2] && !samp[m_n-3];
            if (m_deliver) begin
                for (int p = 0; p < 2; p++) begin
                    exp_dir[p]  = model_dir(p);
                    exp_jump[p] = pend[p];
                    pend[p]     = 1'b0;
                end
                exp_tick = 1'b1;
            end else begin
                exp_jump[0] = 1'b0;
                exp_jump[1] = 1'b0;
                exp_tick    = 1'b0;
            end
            samp.push_back(frame_clk);
            if (samp.size() > 3) void'(samp.pop_front());
            if (key_valid) begin
                lookup(key_code, m_p, m_r);
                if (m_p >= 0) begin
                    if (key_make) begin
                        if (!held[m_p][m_r]) begin
                            held[m_p][m_r] = 1'b1;
                            if (m_r < 2) ptime[m_p][m_r] = cyc;
                            else pend[m_p] = 1'b1;
                        end
                    end else begin
                        held[m_p][m_r] = 1'b0;
                    end
                end
            end
        end
    end

    // Compare every output against the model each cycle.
    always @(posedge Clk) begin
        #2;
        check("fireboy_dir",  fireboy_dir,  exp_dir[0]);
        check("icegirl_dir",  icegirl_dir,  exp_dir[1]);
        check("fireboy_jump", fireboy_jump, exp_jump[0]);
        check("icegirl_jump", icegirl_jump, exp_jump[1]);
        check("frame_tick",   frame_tick,   exp_tick);
        if (fireboy_jump === 1'b1) fb_pulses++;
        if (icegirl_jump === 1'b1) ig_pulses++;
        if (frame_tick === 1'b1) tick_pulses++;
    end

    task automatic key_ev(input logic [7:0] code, input logic mk);
        key_valid = 1'b1;
        key_code  = code;
        key_make  = mk;
        @(negedge Clk);
        key_valid = 1'b0;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    logic [7:0] codes [8] = '{8'h04, 8'h07, 8'h1A, 8'h50, 8'h4F, 8'h52, 8'h29, 8'h00};
    int t0, j0, fc_left, sel;

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; key_valid = 1'b0; key_code = 8'h00; key_make = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // reset and idle
        t0 = tick_pulses;
        frame();
        frame();
        check("idle_ticks", 8'(tick_pulses - t0), 8'd2);
        check("idle_fb_dir", fireboy_dir, 8'h00);
        check("idle_ig_dir", icegirl_dir, 8'h00);
        check("idle_jumps", 8'(fb_pulses + ig_pulses), 8'd0);

        // direction holds across frames
        key_ev(8'h07, 1'b1);
        frame();
        check("hold_fb_right", fireboy_dir, 8'h02);
        check("hold_ig_none", icegirl_dir, 8'h00);
        repeat (3) frame();
        check("hold_fb_stays", fireboy_dir, 8'h02);
        key_ev(8'h07, 1'b0);
        frame();
        check("release_fb_none", fireboy_dir, 8'h00);

        // left/right conflict
        key_ev(8'h50, 1'b1);
        key_ev(8'h4F, 1'b1);
        frame();
        check("conflict_last_wins", icegirl_dir, 8'h02);
        key_ev(8'h4F, 1'b0);
        frame();
        check("conflict_fallback", icegirl_dir, 8'h01);
        key_ev(8'h50, 1'b0);
        frame();

        // jump is edge-only
        j0 = fb_pulses;
        key_ev(8'h1A, 1'b1);
        repeat (5) key_ev(8'h1A, 1'b1);
        repeat (3) frame();
        check("jump_single", 8'(fb_pulses - j0), 8'd1);
        key_ev(8'h1A, 1'b0);
        key_ev(8'h1A, 1'b1);
        frame();
        check("jump_rearm", 8'(fb_pulses - j0), 8'd2);
        key_ev(8'h1A, 1'b0);
        key_ev(8'h1A, 1'b1);
        key_ev(8'h1A, 1'b0);
        key_ev(8'h1A, 1'b1);
        key_ev(8'h1A, 1'b0);
        frame();
        check("jump_collapse", 8'(fb_pulses - j0), 8'd3);

        // same-cycle collision of key event and tick
        t0 = tick_pulses;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        key_ev(8'h04, 1'b1);
        check("collision_ticked", 8'(tick_pulses - t0), 8'd1);
        check("collision_not_yet", fireboy_dir, 8'h00);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame();
        check("collision_next", fireboy_dir, 8'h01);
        key_ev(8'h04, 1'b0);
        frame();

        // unknown code, then reset with a pending jump
        j0 = fb_pulses;
        key_ev(8'h29, 1'b1);
        frame();
        check("unknown_fb", fireboy_dir, 8'h00);
        check("unknown_ig", icegirl_dir, 8'h00);
        check("unknown_jump", 8'(fb_pulses - j0), 8'd0);
        key_ev(8'h29, 1'b0);
        key_ev(8'h07, 1'b1);
        frame();
        check("pre_reset_dir", fireboy_dir, 8'h02);
        key_ev(8'h1A, 1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("reset_async_dir", fireboy_dir, 8'h00);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        j0 = fb_pulses;
        frame();
        check("reset_no_jump", 8'(fb_pulses - j0), 8'd0);
        check("reset_dir_clear", fireboy_dir, 8'h00);

        // frame_clk high across reset release
        Reset = 1'b1;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        t0 = tick_pulses;
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check("high_release_no_tick", 8'(tick_pulses - t0), 8'd0);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        frame();
        check("high_release_then_tick", 8'(tick_pulses - t0), 8'd1);

        // random traffic
        fc_left = 3;
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 499) == 0);
            if (fc_left == 0) begin
                frame_clk = ~frame_clk;
                fc_left = $urandom_range(1, 8);
            end else begin
                fc_left--;
            end
            key_valid = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 7);
            key_code = (sel == 7) ? 8'($urandom_range(0, 255)) : codes[sel];
            key_make = $urandom_range(0, 9) < 6;
            @(negedge Clk);
        end
        Reset = 1'b0;
        key_valid = 1'b0;
        repeat (5) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
